// File: rtl/fwd_network.sv
// fwd_network: ID/EX operand forwarding with load-use stall and registered EX operands.
// Defining FWD_PERF_EN builds saturating stall / forwarded-operand counters.
module fwd_network #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_NUM    = 32,
    parameter int NUM_RS     = 2,
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = 1,
    localparam int RW        = $clog2(REG_NUM)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         id_valid,
    output logic                         id_ready,
    input  logic [NUM_RS*RW-1:0]         id_rs,
    input  logic [RW-1:0]                id_rd,
    input  logic                         id_rd_we,
    input  logic                         id_is_load,
    input  logic [NUM_RS*DATA_WIDTH-1:0] rf_data,
    input  logic [STAGES*DATA_WIDTH-1:0] stage_data,
    output logic                         ex_valid,
    output logic [NUM_RS*DATA_WIDTH-1:0] ex_operand,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_fwd_cnt
);
    logic [STAGES-1:0]            r_tv, r_twe, r_tld;
    logic [RW-1:0]                r_trd [STAGES];
    logic [STAGES-1:0]            w_match [NUM_RS];
    logic [NUM_RS-1:0]            w_late;
    logic [NUM_RS*DATA_WIDTH-1:0] w_op, r_ex_op;
    logic                         w_fire, r_ex_valid;

    // Scan oldest to youngest so the youngest match overwrites and sets the hazard flag.
    always_comb begin
        w_op    = rf_data;
        w_late  = '0;
        w_match = '{default: '0};
        for (int i = 0; i < NUM_RS; i++) begin
            for (int k = 0; k < STAGES; k++)
                w_match[i][k] = r_tv[k] && r_twe[k] && id_rs[i*RW +: RW] != '0 && r_trd[k] == id_rs[i*RW +: RW];
            for (int k = STAGES-1; k >= 0; k--) begin
                if (w_match[i][k]) begin
                    w_op[i*DATA_WIDTH +: DATA_WIDTH] = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
                    w_late[i] = r_tld[k] && (k < LOAD_STAGE);
                end
            end
            if (id_rs[i*RW +: RW] == '0)
                w_op[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
    end

    assign id_ready   = ~|w_late;
    assign w_fire     = id_valid && id_ready;
    assign ex_valid   = r_ex_valid;
    assign ex_operand = r_ex_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tv       <= '0;
            r_twe      <= '0;
            r_tld      <= '0;
            r_trd      <= '{default: '0};
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
        end else begin
            for (int k = STAGES-1; k > 0; k--) begin
                r_tv[k]  <= r_tv[k-1] && !flush;
                r_twe[k] <= r_twe[k-1];
                r_tld[k] <= r_tld[k-1];
                r_trd[k] <= r_trd[k-1];
            end
            r_tv[0]    <= w_fire && !flush;
            r_twe[0]   <= id_rd_we;
            r_tld[0]   <= id_is_load;
            r_trd[0]   <= id_rd;
            r_ex_valid <= w_fire && !flush;
            if (w_fire && !flush)
                r_ex_op <= w_op;
        end
    end

`ifdef FWD_PERF_EN
    logic [31:0] r_stall, r_fwd;
    logic [32:0] w_fwd_sum;

    always_comb begin
        w_fwd_sum = {1'b0, r_fwd};
        for (int i = 0; i < NUM_RS; i++)
            w_fwd_sum = w_fwd_sum + 33'(|w_match[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_fwd   <= '0;
        end else begin
            if (id_valid && !id_ready && !flush && r_stall != '1)
                r_stall <= r_stall + 32'd1;
            if (w_fire)
                r_fwd <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
        end
    end

    assign perf_stall_cnt = r_stall;
    assign perf_fwd_cnt   = r_fwd;
`else
    assign perf_stall_cnt = '0;
    assign perf_fwd_cnt   = '0;
`endif
endmodule

// File: tb/tb_fwd_network.sv
// tb_fwd_network: directed vectors checked every cycle against an in-flight queue model.
module tb_fwd_network;
    localparam int DW = 64, RN = 32, NRS = 2, ST = 3, LS = 1, RW = 5;

    logic                clk, rst_n, flush, id_valid, id_ready, id_rd_we, id_is_load, ex_valid;
    logic [NRS*RW-1:0]   id_rs;
    logic [RW-1:0]       id_rd;
    logic [NRS*DW-1:0]   rf_data, ex_operand;
    logic [ST*DW-1:0]    stage_data;
    logic [31:0]         perf_stall_cnt, perf_fwd_cnt;

    int vectors = 0, fails = 0;

    fwd_network #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RS(NRS), .STAGES(ST), .LOAD_STAGE(LS)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .rf_data(rf_data), .stage_data(stage_data), .ex_valid(ex_valid), .ex_operand(ex_operand),
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: queue of the last ST issue slots, index 0 = most recent.
    typedef struct {bit v; bit [RW-1:0] rd; bit we; bit ld;} tag_t;
    tag_t      q[$];
    bit        m_exv;
    bit [NRS*DW-1:0] m_op;
    bit [31:0] m_stall, m_fwd;

    function automatic void predict(output bit [NRS*DW-1:0] ops, output bit haz, output int nf);
        haz = 0;
        nf  = 0;
        for (int i = 0; i < NRS; i++) begin
            bit [RW-1:0] rs = id_rs[i*RW +: RW];
            ops[i*DW +: DW] = rf_data[i*DW +: DW];
            if (rs == 0) begin
                ops[i*DW +: DW] = 0;
                continue;
            end
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].v && q[k].we && q[k].rd == rs) begin
                    ops[i*DW +: DW] = stage_data[k*DW +: DW];
                    if (q[k].ld && k < LS) haz = 1;
                    nf++;
                    break;
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit [NRS*DW-1:0] ops;
        bit haz, fire;
        int nf;
        tag_t t;
        if (!rst_n) begin
            q.delete();
            for (int k = 0; k < ST; k++) q.push_back('{0, 0, 0, 0});
            m_exv = 0; m_op = 0; m_stall = 0; m_fwd = 0;
        end else begin
            predict(ops, haz, nf);
            fire = id_valid && !haz;
            if (id_valid && haz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (fire) m_fwd = (64'(m_fwd) + nf > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_fwd + nf;
            if (flush) begin
                for (int k = 0; k < ST; k++) q[k].v = 0;
                m_exv = 0;
            end else begin
                t.v = fire; t.rd = id_rd; t.we = id_rd_we; t.ld = id_is_load;
                q.push_front(t);
                void'(q.pop_back());
                m_exv = fire;
                if (fire) m_op = ops;
            end
        end
    end

    task automatic chk(input string n, input logic [NRS*DW-1:0] a, input logic [NRS*DW-1:0] e);
        vectors++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic compare_all();
        bit [NRS*DW-1:0] ops;
        bit haz;
        int nf;
        predict(ops, haz, nf);
        chk("id_ready", id_ready, !haz);
        chk("ex_valid", ex_valid, m_exv);
        chk("ex_operand", ex_operand, m_op);
`ifdef FWD_PERF_EN
        chk("perf_stall", perf_stall_cnt, m_stall);
        chk("perf_fwd", perf_fwd_cnt, m_fwd);
`else
        chk("perf_stall_off", perf_stall_cnt, 0);
        chk("perf_fwd_off", perf_fwd_cnt, 0);
`endif
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input bit [RW-1:0] rs0, rs1, rd, input bit we, ld);
        id_valid = v; id_rs = {rs1, rs0}; id_rd = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task automatic set_rf(input logic [DW-1:0] a, b);
        rf_data = {b, a};
    endtask

    task automatic set_sd(input logic [DW-1:0] s0, s1, s2);
        stage_data = {s2, s1, s0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0); set_rf(0, 0); set_sd(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_ready", id_ready, 1);
        chk("rst_exv", ex_valid, 0);
        chk("rst_op", ex_operand, 0);
        rst_n = 1;
        set_id(1, 5, 6, 0, 0, 0); set_rf(64'h11, 64'h22); tick();
        chk("rf_path", ex_operand, {64'h22, 64'h11});
        chk("rf_exv", ex_valid, 1);
        set_id(1, 0, 0, 5, 1, 0); tick();
        set_id(1, 5, 0, 0, 0, 0); set_sd(64'hAAAA, 0, 0);
        #1 chk("alu_ready", id_ready, 1);
        tick();
        chk("fwd_s0", ex_operand, {64'h0, 64'hAAAA});
        set_sd(64'hAAAA, 64'hBBBB, 0); tick();
        chk("fwd_s1", ex_operand, {64'h0, 64'hBBBB});
        set_id(1, 0, 0, 7, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0); tick();
        set_id(1, 0, 0, 7, 1, 0); tick();
        set_id(1, 7, 0, 0, 0, 0); set_sd(64'h1, 64'h2, 64'h3); tick();
        chk("youngest", ex_operand, {64'h0, 64'h1});
        set_id(1, 0, 0, 9, 1, 0); tick();
        set_id(1, 0, 0, 9, 1, 1); tick();
        set_id(1, 0, 9, 0, 0, 0); set_sd(64'hDEAD, 64'hC0DE, 64'hBAD); set_rf(0, 64'h99);
        #1 chk("lu_stall", id_ready, 0);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_resolved", id_ready, 1);
        tick();
        chk("lu_fwd", ex_operand, {64'hC0DE, 64'h0});
        chk("lu_exv", ex_valid, 1);
        set_id(1, 0, 0, 0, 1, 0); tick();
        set_id(1, 0, 0, 0, 0, 0); set_rf(64'hFFFF, 64'hFFFF); set_sd(64'h1234, 64'h5, 64'h6); tick();
        chk("rs_zero", ex_operand, 0);
        set_id(1, 0, 0, 12, 1, 0); tick();
        set_id(1, 0, 0, 13, 1, 0); tick();
        set_id(1, 12, 13, 0, 0, 0); set_rf(64'h55, 64'h66); set_sd(64'h7, 64'h8, 64'h9); flush = 1;
        #1 chk("flush_ready", id_ready, 1);
        tick();
        flush = 0;
        chk("flush_exv", ex_valid, 0);
        tick();
        chk("post_flush", ex_operand, {64'h66, 64'h55});
        set_id(1, 0, 0, 20, 1, 1); tick();
        set_id(1, 20, 0, 0, 0, 0); set_sd(64'hE, 64'hF, 0);
        #1 chk("pre_rst_stall", id_ready, 0);
        #1 rst_n = 0;
        #1;
        chk("async_ready", id_ready, 1);
        chk("async_exv", ex_valid, 0);
        chk("async_op", ex_operand, 0);
        tick();
        rst_n = 1;
        set_rf(64'h77, 0); tick();
        chk("post_rst", ex_operand, {64'h0, 64'h77});
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
